buzzer_tone_gen: RTL and testbench

Drives the piano buzzer pin from the 10-bit note word produced by the keyboard/switch front end. Bits 0–6 select do–si and bits 7–9 select the octave. The block synchronises the word and priority-decodes it to one note and one octave. It then generates a 50 % duty square wave at that pitch by dividing the system clock, switching pitch only at half-period boundaries so the buzzer never sees a glitch pulse.

---
 rtl/pianista_pkg.sv | 45 ++++
 rtl/note_decoder.sv | 56 +++++
 rtl/buzzer_tone_gen.sv | 96 +++++++++
 tb/tb_buzzer_tone_gen.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pianista_pkg.sv
// Shared constants for the piano buzzer: note frequencies, octave codes, FSM states
// and the half-period lookup that turns a decoded note/octave into a clock count.
package pianista_pkg;

  localparam int F_DO  = 262;
  localparam int F_RE  = 294;
  localparam int F_MI  = 330;
  localparam int F_FA  = 349;
  localparam int F_SOL = 392;
  localparam int F_LA  = 440;
  localparam int F_SI  = 494;

  localparam logic [1:0] OCT_LOW  = 2'd0;
  localparam logic [1:0] OCT_MID  = 2'd1;
  localparam logic [1:0] OCT_HIGH = 2'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } state_t;

  // Each branch divides constants only, so with a parameter clk_hz this folds to a small mux.
  function automatic logic [31:0] half_period(input logic [2:0]  note,
                                              input logic [1:0]  oct,
                                              input int unsigned clk_hz);
    logic [31:0] base;
    logic [31:0] half;
    case (note)
      3'd0:    base = clk_hz / (2 * F_DO);
      3'd1:    base = clk_hz / (2 * F_RE);
      3'd2:    base = clk_hz / (2 * F_MI);
      3'd3:    base = clk_hz / (2 * F_FA);
      3'd4:    base = clk_hz / (2 * F_SOL);
      3'd5:    base = clk_hz / (2 * F_LA);
      default: base = clk_hz / (2 * F_SI);
    endcase
    case (oct)
      OCT_LOW:  half = base << 1;
      OCT_HIGH: half = base >> 1;
      default:  half = base;
    endcase
    return half;
  endfunction

endpackage

// File: rtl/note_decoder.sv
// Brings the asynchronous note word into the clock domain (2 flops) and registers a
// priority decode: lowest note bit wins, lowest octave bit wins, no octave bit means mid.
module note_decoder
  import pianista_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] i_note_word,
  output logic       req_valid,
  output logic [2:0] req_note,
  output logic [1:0] req_oct
);

  logic [9:0] r_sync1;
  logic [9:0] r_sync2;
  logic       r_valid;
  logic [2:0] r_note;
  logic [1:0] r_oct;

  logic       w_valid;
  logic [2:0] w_note;
  logic [1:0] w_oct;

  always_comb begin
    w_valid = |r_sync2[6:0];
    w_note  = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (r_sync2[i]) w_note = 3'(i);
    end
    w_oct = OCT_MID;
    if (r_sync2[9]) w_oct = OCT_HIGH;
    if (r_sync2[8]) w_oct = OCT_MID;
    if (r_sync2[7]) w_oct = OCT_LOW;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_valid <= 1'b0;
      r_note  <= '0;
      r_oct   <= '0;
    end else begin
      r_sync1 <= i_note_word;
      r_sync2 <= r_sync1;
      r_valid <= w_valid;
      r_note  <= w_note;
      r_oct   <= w_oct;
    end
  end

  assign req_valid = r_valid;
  assign req_note  = r_note;
  assign req_oct   = r_oct;

endmodule

// File: rtl/buzzer_tone_gen.sv
// Square-wave buzzer driver: divides clk to the decoded note's half-period and only
// re-samples the request at half-period boundaries, so pitch changes never glitch.
module buzzer_tone_gen
  import pianista_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int          CNT_W  = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] BuzzerNote,
  output logic       buzzer,
  output logic       playing,
  output logic [2:0] note_idx,
  output logic [1:0] octave
);

  logic             w_req_valid;
  logic [2:0]       w_req_note;
  logic [1:0]       w_req_oct;
  logic [CNT_W-1:0] w_half;
  logic             w_boundary;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_half;
  logic             r_buzzer;
  logic             r_playing;
  logic [2:0]       r_note;
  logic [1:0]       r_oct;

  note_decoder u_note_decoder (
    .clk         (clk),
    .rst         (rst),
    .i_note_word (BuzzerNote),
    .req_valid   (w_req_valid),
    .req_note    (w_req_note),
    .req_oct     (w_req_oct)
  );

  assign w_half     = CNT_W'(half_period(w_req_note, w_req_oct, CLK_HZ));
  assign w_boundary = (r_cnt == r_half - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_half    <= '0;
      r_buzzer  <= 1'b0;
      r_playing <= 1'b0;
      r_note    <= 3'd0;
      r_oct     <= OCT_MID;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt    <= '0;
          r_buzzer <= 1'b0;
          if (w_req_valid) begin
            r_state   <= ST_PLAY;
            r_buzzer  <= 1'b1;
            r_playing <= 1'b1;
            r_half    <= w_half;
            r_note    <= w_req_note;
            r_oct     <= w_req_oct;
          end
        end
        ST_PLAY: begin
          if (w_boundary) begin
            r_cnt <= '0;
            if (w_req_valid) begin
              r_buzzer <= ~r_buzzer;
              r_half   <= w_half;
              r_note   <= w_req_note;
              r_oct    <= w_req_oct;
            end else begin
              // Release only at a boundary so the last phase is always full length.
              r_state   <= ST_IDLE;
              r_buzzer  <= 1'b0;
              r_playing <= 1'b0;
              r_note    <= 3'd0;
              r_oct     <= OCT_MID;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign buzzer   = r_buzzer;
  assign playing  = r_playing;
  assign note_idx = r_note;
  assign octave   = r_oct;

endmodule

// File: tb/tb_buzzer_tone_gen.sv
// Directed bench for buzzer_tone_gen at CLK_HZ = 1 MHz (la mid half = 1136, do mid = 1908).
module tb_buzzer_tone_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] BuzzerNote = '0;
  logic       buzzer;
  logic       playing;
  logic [2:0] note_idx;
  logic [1:0] octave;

  int checks = 0;
  int errors = 0;

  localparam logic [9:0] LA_MID = 10'b01_0010_0000;
  localparam logic [9:0] DO_MID = 10'b01_0000_0001;
  localparam logic [9:0] MI_MID = 10'b01_0000_0100;
  localparam int LIMIT = 9000;

  buzzer_tone_gen #(.CLK_HZ(1_000_000), .CNT_W(20)) dut (
    .clk        (clk),
    .rst        (rst),
    .BuzzerNote (BuzzerNote),
    .buzzer     (buzzer),
    .playing    (playing),
    .note_idx   (note_idx),
    .octave     (octave)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_rise();
    int n = 0;
    while (buzzer !== 1'b1 && n < LIMIT) begin
      tick();
      n++;
    end
    checks++;
    if (buzzer !== 1'b1) begin
      errors++;
      $display("FAIL wait_rise: buzzer=%b after %0d cycles, required 1", buzzer, n);
    end
  endtask

  task automatic measure_phase(output int n);
    logic lvl;
    lvl = buzzer;
    n = 0;
    do begin
      tick();
      n++;
    end while (buzzer === lvl && n < LIMIT);
  endtask

  task automatic go_idle();
    int n = 0;
    BuzzerNote = '0;
    while (playing !== 1'b0 && n < LIMIT) begin
      tick();
      n++;
    end
    checks++;
    if (playing !== 1'b0) begin
      errors++;
      $display("FAIL go_idle: playing=%b after %0d cycles, required 0", playing, n);
    end
    tick(8);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    BuzzerNote = LA_MID;
    tick(6);
    checks++;
    if (buzzer !== 1'b0) begin errors++; $display("FAIL reset_buzzer: got %b required 0", buzzer); end
    checks++;
    if (playing !== 1'b0) begin errors++; $display("FAIL reset_playing: got %b required 0", playing); end
    checks++;
    if (note_idx !== 3'd0) begin errors++; $display("FAIL reset_note_idx: got %0d required 0", note_idx); end
    checks++;
    if (octave !== 2'd1) begin errors++; $display("FAIL reset_octave: got %0d required 1", octave); end
    BuzzerNote = '0;
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_single_note();
    int n;
    BuzzerNote = LA_MID;
    tick(3);
    checks++;
    if (buzzer !== 1'b0 || playing !== 1'b0) begin
      errors++;
      $display("FAIL single_early: buzzer=%b playing=%b at +3, required 0 0", buzzer, playing);
    end
    tick();
    checks++;
    if (buzzer !== 1'b1 || playing !== 1'b1) begin
      errors++;
      $display("FAIL single_latency: buzzer=%b playing=%b at +4, required 1 1", buzzer, playing);
    end
    checks++;
    if (note_idx !== 3'd5 || octave !== 2'd1) begin
      errors++;
      $display("FAIL single_note: note_idx=%0d octave=%0d, required 5 1", note_idx, octave);
    end
    measure_phase(n);
    checks++;
    if (n != 1136) begin errors++; $display("FAIL single_high: got %0d cycles required 1136", n); end
    measure_phase(n);
    checks++;
    if (n != 1136) begin errors++; $display("FAIL single_low: got %0d cycles required 1136", n); end
    go_idle();
  endtask

  task automatic test_reset_mid_play();
    BuzzerNote = LA_MID;
    wait_rise();
    tick(300);
    rst = 1'b1;
    tick();
    checks++;
    if (buzzer !== 1'b0 || playing !== 1'b0 || note_idx !== 3'd0 || octave !== 2'd1) begin
      errors++;
      $display("FAIL midplay_reset: buzzer=%b playing=%b note_idx=%0d octave=%0d, required 0 0 0 1",
               buzzer, playing, note_idx, octave);
    end
    BuzzerNote = '0;
    tick();
    rst = 1'b0;
    tick(8);
    checks++;
    if (buzzer !== 1'b0 || playing !== 1'b0) begin
      errors++;
      $display("FAIL midplay_after: buzzer=%b playing=%b, required 0 0", buzzer, playing);
    end
  endtask

  task automatic test_octave();
    logic [9:0] word;
    int         exp_half;
    logic [1:0] exp_oct;
    int         n;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin word = 10'b00_1010_0000; exp_half = 2272; exp_oct = 2'd0; end
      else        begin word = 10'b10_0010_0000; exp_half = 568;  exp_oct = 2'd2; end
      BuzzerNote = word;
      wait_rise();
      checks++;
      if (note_idx !== 3'd5 || octave !== exp_oct) begin
        errors++;
        $display("FAIL octave_sel[%0d]: note_idx=%0d octave=%0d, required 5 %0d", k, note_idx, octave, exp_oct);
      end
      measure_phase(n);
      checks++;
      if (n != exp_half) begin
        errors++;
        $display("FAIL octave_half[%0d]: got %0d cycles required %0d", k, n, exp_half);
      end
      go_idle();
    end
  endtask

  task automatic test_priority();
    logic [9:0] word;
    int         exp_half;
    logic [1:0] exp_oct;
    int         n;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin word = 10'b11_1000_0101; exp_half = 3816; exp_oct = 2'd0; end
      else        begin word = 10'b11_0000_0101; exp_half = 1908; exp_oct = 2'd1; end
      BuzzerNote = word;
      wait_rise();
      checks++;
      if (note_idx !== 3'd0 || octave !== exp_oct) begin
        errors++;
        $display("FAIL prio_sel[%0d]: note_idx=%0d octave=%0d, required 0 %0d", k, note_idx, octave, exp_oct);
      end
      measure_phase(n);
      checks++;
      if (n != exp_half) begin
        errors++;
        $display("FAIL prio_half[%0d]: got %0d cycles required %0d", k, n, exp_half);
      end
      go_idle();
    end
  endtask

  task automatic test_glitch_free();
    int n;
    BuzzerNote = LA_MID;
    wait_rise();
    tick(500);
    n = 500;
    BuzzerNote = DO_MID;
    while (buzzer === 1'b1 && n < LIMIT) begin
      tick();
      n++;
    end
    checks++;
    if (n != 1136) begin errors++; $display("FAIL change_cur_phase: got %0d cycles required 1136", n); end
    checks++;
    if (note_idx !== 3'd0 || octave !== 2'd1) begin
      errors++;
      $display("FAIL change_note: note_idx=%0d octave=%0d, required 0 1", note_idx, octave);
    end
    measure_phase(n);
    checks++;
    if (n != 1908) begin errors++; $display("FAIL change_next_phase: got %0d cycles required 1908", n); end
    go_idle();
  endtask

  task automatic test_release();
    int n;
    BuzzerNote = LA_MID;
    wait_rise();
    tick(500);
    n = 500;
    BuzzerNote = '0;
    while (buzzer === 1'b1 && n < LIMIT) begin
      tick();
      n++;
    end
    checks++;
    if (n != 1136) begin errors++; $display("FAIL release_phase: got %0d cycles required 1136", n); end
    checks++;
    if (playing !== 1'b0 || note_idx !== 3'd0 || octave !== 2'd1) begin
      errors++;
      $display("FAIL release_state: playing=%b note_idx=%0d octave=%0d, required 0 0 1", playing, note_idx, octave);
    end
    tick(2000);
    checks++;
    if (buzzer !== 1'b0 || playing !== 1'b0) begin
      errors++;
      $display("FAIL release_quiet: buzzer=%b playing=%b, required 0 0", buzzer, playing);
    end
  endtask

  task automatic test_short_pulse();
    int n;
    BuzzerNote = LA_MID;
    wait_rise();
    tick(200);
    BuzzerNote = MI_MID;
    tick(100);
    BuzzerNote = LA_MID;
    n = 300;
    while (buzzer === 1'b1 && n < LIMIT) begin
      tick();
      n++;
    end
    checks++;
    if (n != 1136 || note_idx !== 3'd5) begin
      errors++;
      $display("FAIL pulse_phase: %0d cycles note_idx=%0d, required 1136 5", n, note_idx);
    end
    measure_phase(n);
    checks++;
    if (n != 1136 || note_idx !== 3'd5) begin
      errors++;
      $display("FAIL pulse_next: %0d cycles note_idx=%0d, required 1136 5", n, note_idx);
    end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_single_note();
    test_reset_mid_play();
    test_octave();
    test_priority();
    test_glitch_free();
    test_release();
    test_short_pulse();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
